// File: rtl/vga_timing_pkg.sv
// Mode constants for 800x600@72Hz on a 50 MHz pixel clock, shared by the
// raster generator and the object bank.
package vga_timing_pkg;

    localparam logic [10:0] H_VISIBLE    = 11'd800;
    localparam logic [10:0] H_FP         = 11'd56;
    localparam logic [10:0] H_SYNC       = 11'd120;
    localparam logic [10:0] H_BP         = 11'd64;
    localparam logic [10:0] H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam logic [10:0] H_SYNC_START = H_VISIBLE + H_FP;

    localparam logic [9:0]  V_VISIBLE    = 10'd600;
    localparam logic [9:0]  V_FP         = 10'd37;
    localparam logic [9:0]  V_SYNC       = 10'd6;
    localparam logic [9:0]  V_BP         = 10'd23;
    localparam logic [9:0]  V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  V_SYNC_START = V_VISIBLE + V_FP;

    localparam int RGB_W = 6;

    typedef logic [RGB_W-1:0] rgb_t;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } sync_bits_t;

endpackage

// File: rtl/sync_delay_line.sv
// WIDTH x DEPTH register shift pipe; every stage resets to RST_VAL.
// DEPTH must be at least 1 (a zero-depth pipe is a plain wire at the caller).
module sync_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RST_VAL;
            end
        end else begin
            r_stage[0] <= d_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign d_out = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, sync/blank generation and frame/line ticks for the VGA port.
// Sync and blank are delayed to line up with the object bank's pixel latency.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter logic [10:0] H_VISIBLE     = vga_timing_pkg::H_VISIBLE,
    parameter logic [10:0] H_FP          = vga_timing_pkg::H_FP,
    parameter logic [10:0] H_SYNC        = vga_timing_pkg::H_SYNC,
    parameter logic [10:0] H_BP          = vga_timing_pkg::H_BP,
    parameter logic [9:0]  V_VISIBLE     = vga_timing_pkg::V_VISIBLE,
    parameter logic [9:0]  V_FP          = vga_timing_pkg::V_FP,
    parameter logic [9:0]  V_SYNC        = vga_timing_pkg::V_SYNC,
    parameter logic [9:0]  V_BP          = vga_timing_pkg::V_BP,
    parameter bit          HSYNC_POL     = 1'b1,
    parameter bit          VSYNC_POL     = 1'b1,
    parameter int          PIXEL_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [vga_timing_pkg::RGB_W-1:0] pixel_in,
    output logic [10:0]                      cntr_h,
    output logic [9:0]                       cntr_v,
    output logic                             frame_tick,
    output logic                             line_tick,
    output logic                             hsync,
    output logic                             vsync,
    output logic                             blank,
    output logic [vga_timing_pkg::RGB_W-1:0] rgb_out
);

    localparam logic [10:0] H_LAST     = H_VISIBLE + H_FP + H_SYNC + H_BP - 11'd1;
    localparam logic [10:0] H_SYNC_BEG = H_VISIBLE + H_FP;
    localparam logic [10:0] H_SYNC_END = H_VISIBLE + H_FP + H_SYNC;
    localparam logic [9:0]  V_LAST     = V_VISIBLE + V_FP + V_SYNC + V_BP - 10'd1;
    localparam logic [9:0]  V_SYNC_BEG = V_VISIBLE + V_FP;
    localparam logic [9:0]  V_SYNC_END = V_VISIBLE + V_FP + V_SYNC;

    logic [10:0] r_cntr_h;
    logic [9:0]  r_cntr_v;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_blank;
    rgb_t        r_rgb;
    sync_bits_t  w_raw;
    sync_bits_t  w_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cntr_h <= '0;
            r_cntr_v <= '0;
        end else if (r_cntr_h == H_LAST) begin
            r_cntr_h <= '0;
            r_cntr_v <= (r_cntr_v == V_LAST) ? '0 : r_cntr_v + 10'd1;
        end else begin
            r_cntr_h <= r_cntr_h + 11'd1;
        end
    end

    assign w_raw.active = (r_cntr_h < H_VISIBLE) && (r_cntr_v < V_VISIBLE);
    assign w_raw.hs     = (r_cntr_h >= H_SYNC_BEG) && (r_cntr_h < H_SYNC_END);
    assign w_raw.vs     = (r_cntr_v >= V_SYNC_BEG) && (r_cntr_v < V_SYNC_END);

    // Raw decode is held back so it meets pixel_in for the same counter value.
    if (PIXEL_LATENCY > 0) begin : g_pipe
        sync_delay_line #(
            .WIDTH   (3),
            .DEPTH   (PIXEL_LATENCY),
            .RST_VAL (3'b000)
        ) u_sync_delay (
            .clk   (clk),
            .rst_n (rst_n),
            .d_in  (w_raw),
            .d_out (w_dly)
        );
    end else begin : g_no_pipe
        assign w_dly = w_raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync <= ~HSYNC_POL;
            r_vsync <= ~VSYNC_POL;
            r_blank <= 1'b1;
            r_rgb   <= '0;
        end else begin
            r_hsync <= w_dly.hs ? HSYNC_POL : ~HSYNC_POL;
            r_vsync <= w_dly.vs ? VSYNC_POL : ~VSYNC_POL;
            r_blank <= ~w_dly.active;
            r_rgb   <= w_dly.active ? pixel_in : '0;
        end
    end

    assign cntr_h     = r_cntr_h;
    assign cntr_v     = r_cntr_v;
    assign frame_tick = (r_cntr_h == H_VISIBLE) && (r_cntr_v == V_VISIBLE);
    assign line_tick  = (r_cntr_h == H_LAST);
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign blank      = r_blank;
    assign rgb_out    = r_rgb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full 800x600 instance plus two shrunken modes that
// make frame-level behaviour (vsync, frame wrap, frame_tick) reachable quickly.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       bl;
        logic [5:0] rgb;
    } out_t;

    typedef struct {
        int d; int n; int h; int v;
        int lt; int ft; int hs; int vs; int bl; int rgb;
    } vec_t;

    // Per-instance mode: 0 = full 800x600, 1 = tiny (L=0, hsync low-active), 2 = tiny (L=3, vsync low-active)
    int HV  [3] = '{800, 16, 20};
    int HFP [3] = '{56, 2, 3};
    int HSW [3] = '{120, 3, 4};
    int HBP [3] = '{64, 2, 3};
    int VV  [3] = '{600, 6, 4};
    int VFP [3] = '{37, 1, 2};
    int VSW [3] = '{6, 2, 3};
    int VBP [3] = '{23, 1, 2};
    int HP  [3] = '{1, 0, 1};
    int VP  [3] = '{1, 1, 0};
    int LAT [3] = '{1, 0, 3};
    int FRAME_LEN [3] = '{692640, 230, 330};
    int FIRST_FT  [3] = '{624800, 154, 140};

    logic              clk;
    logic [2:0]        rstn;
    logic [2:0][5:0]   pix;
    logic [2:0][10:0]  ch;
    logic [2:0][9:0]   cv;
    logic [2:0]        ft, lt, hs, vs, bl;
    logic [2:0][5:0]   rgb;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   nrel [3];
    int   last_ft [3];
    bit   in_rst [3];
    bit   tbl_en;
    int   vec_hits = 0;
    vec_t vec_q [$];
    out_t q0 [$];
    out_t q1 [$];
    out_t q2 [$];

    vga_timing_gen #(.PIXEL_LATENCY(1)) u_dut_a (
        .clk(clk), .rst_n(rstn[0]), .pixel_in(pix[0]), .cntr_h(ch[0]), .cntr_v(cv[0]),
        .frame_tick(ft[0]), .line_tick(lt[0]), .hsync(hs[0]), .vsync(vs[0]),
        .blank(bl[0]), .rgb_out(rgb[0]));

    vga_timing_gen #(
        .H_VISIBLE(11'd16), .H_FP(11'd2), .H_SYNC(11'd3), .H_BP(11'd2),
        .V_VISIBLE(10'd6), .V_FP(10'd1), .V_SYNC(10'd2), .V_BP(10'd1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .PIXEL_LATENCY(0)
    ) u_dut_b (
        .clk(clk), .rst_n(rstn[1]), .pixel_in(pix[1]), .cntr_h(ch[1]), .cntr_v(cv[1]),
        .frame_tick(ft[1]), .line_tick(lt[1]), .hsync(hs[1]), .vsync(vs[1]),
        .blank(bl[1]), .rgb_out(rgb[1]));

    vga_timing_gen #(
        .H_VISIBLE(11'd20), .H_FP(11'd3), .H_SYNC(11'd4), .H_BP(11'd3),
        .V_VISIBLE(10'd4), .V_FP(10'd2), .V_SYNC(10'd3), .V_BP(10'd2),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .PIXEL_LATENCY(3)
    ) u_dut_c (
        .clk(clk), .rst_n(rstn[2]), .pixel_in(pix[2]), .cntr_h(ch[2]), .cntr_v(cv[2]),
        .frame_tick(ft[2]), .line_tick(lt[2]), .hsync(hs[2]), .vsync(vs[2]),
        .blank(bl[2]), .rgb_out(rgb[2]));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int ht(input int d);
        return HV[d] + HFP[d] + HSW[d] + HBP[d];
    endfunction

    function automatic int vt(input int d);
        return VV[d] + VFP[d] + VSW[d] + VBP[d];
    endfunction

    function automatic logic [5:0] pattern(input int d, input int h, input int v);
        int p;
        p = (d == 0) ? h : h + 7 * v;
        return 6'(p % 64);
    endfunction

    // Pixel the object bank would return for the counter value seen m cycles after release.
    function automatic logic [5:0] pixel_for(input int d, input int m);
        int h, v;
        h = m % ht(d);
        v = (m / ht(d)) % vt(d);
        return (h < HV[d] && v < VV[d]) ? pattern(d, h, v) : 6'h3F;
    endfunction

    function automatic out_t expect_at(input int d, input int h, input int v);
        out_t e;
        bit   vis, hsr, vsr;
        vis   = (h < HV[d]) && (v < VV[d]);
        hsr   = (h >= HV[d] + HFP[d]) && (h < HV[d] + HFP[d] + HSW[d]);
        vsr   = (v >= VV[d] + VFP[d]) && (v < VV[d] + VFP[d] + VSW[d]);
        e.hs  = hsr ? HP[d][0] : ~HP[d][0];
        e.vs  = vsr ? VP[d][0] : ~VP[d][0];
        e.bl  = ~vis;
        e.rgb = vis ? pattern(d, h, v) : 6'd0;
        return e;
    endfunction

    function automatic out_t reset_out(input int d);
        out_t e;
        e.hs  = ~HP[d][0];
        e.vs  = ~VP[d][0];
        e.bl  = 1'b1;
        e.rgb = 6'd0;
        return e;
    endfunction

    task automatic chk(input string name, input int d, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s dut%0d n=%0d cyc=%0d: got %0d expected %0d",
                         name, d, nrel[d], cyc, act, exp);
        end
    endtask

    task automatic push_exp(input int d, input out_t e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int d, output out_t e, output bit ok);
        ok = 1'b1;
        e  = reset_out(d);
        case (d)
            0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
            1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
            default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    task automatic add_vec(input int d, input int n, input int h, input int v, input int l,
                           input int f, input int s, input int w, input int b, input int r);
        vec_t t;
        t.d = d; t.n = n; t.h = h; t.v = v; t.lt = l; t.ft = f;
        t.hs = s; t.vs = w; t.bl = b; t.rgb = r;
        vec_q.push_back(t);
    endtask

    task automatic chk_reset(input int d);
        out_t r;
        r = reset_out(d);
        chk("rst_cntr_h", d, int'(ch[d]), 0);
        chk("rst_cntr_v", d, int'(cv[d]), 0);
        chk("rst_hsync", d, int'(hs[d]), int'(r.hs));
        chk("rst_vsync", d, int'(vs[d]), int'(r.vs));
        chk("rst_blank", d, int'(bl[d]), 1);
        chk("rst_rgb", d, int'(rgb[d]), 0);
        chk("rst_frame_tick", d, int'(ft[d]), 0);
    endtask

    task automatic process(input int d);
        int   h, v;
        out_t e;
        bit   ok;
        h = nrel[d] % ht(d);
        v = (nrel[d] / ht(d)) % vt(d);
        chk("cntr_h", d, int'(ch[d]), h);
        chk("cntr_v", d, int'(cv[d]), v);
        chk("line_tick", d, int'(lt[d]), (h == ht(d) - 1) ? 1 : 0);
        chk("frame_tick", d, int'(ft[d]), (h == HV[d] && v == VV[d]) ? 1 : 0);
        pop_exp(d, e, ok);
        chk("sb_entry", d, int'(ok), 1);
        chk("hsync", d, int'(hs[d]), int'(e.hs));
        chk("vsync", d, int'(vs[d]), int'(e.vs));
        chk("blank", d, int'(bl[d]), int'(e.bl));
        chk("rgb_out", d, int'(rgb[d]), int'(e.rgb));
        push_exp(d, expect_at(d, h, v));
        pix[d] = (nrel[d] >= LAT[d]) ? pixel_for(d, nrel[d] - LAT[d]) : 6'd0;
        if (ft[d]) begin
            if (last_ft[d] >= 0) chk("ft_interval", d, cyc - last_ft[d], FRAME_LEN[d]);
            last_ft[d] = cyc;
        end
        if (tbl_en) begin
            for (int i = 0; i < vec_q.size(); i++) begin
                if (vec_q[i].d == d && vec_q[i].n == nrel[d]) begin
                    vec_hits++;
                    chk("vec_cntr_h", d, int'(ch[d]), vec_q[i].h);
                    chk("vec_cntr_v", d, int'(cv[d]), vec_q[i].v);
                    chk("vec_line_tick", d, int'(lt[d]), vec_q[i].lt);
                    chk("vec_frame_tick", d, int'(ft[d]), vec_q[i].ft);
                    chk("vec_hsync", d, int'(hs[d]), vec_q[i].hs);
                    chk("vec_vsync", d, int'(vs[d]), vec_q[i].vs);
                    chk("vec_blank", d, int'(bl[d]), vec_q[i].bl);
                    chk("vec_rgb", d, int'(rgb[d]), vec_q[i].rgb);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 3; d++) begin
            if (in_rst[d]) begin
                chk_reset(d);
            end else begin
                nrel[d]++;
                process(d);
            end
        end
    endtask

    task automatic release_dut(input int d);
        rstn[d]   = 1'b1;
        in_rst[d] = 1'b0;
        nrel[d]   = 0;
        last_ft[d] = -1;
        case (d)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
        for (int i = 0; i <= LAT[d]; i++) push_exp(d, reset_out(d));
        process(d);
    endtask

    task automatic mid_reset(input int d, input int th, input int tv);
        bit hit;
        int first;
        hit = 1'b0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            if (nrel[d] % ht(d) == th && (tv < 0 || (nrel[d] / ht(d)) % vt(d) == tv)
                && (nrel[d] / ht(d)) % vt(d) < VV[d])
                hit = 1'b1;
            else
                step();
        end
        chk("mid_reset_reached", d, int'(hit), 1);
        #4;
        rstn[d] = 1'b0;
        #1;
        chk_reset(d);
        in_rst[d] = 1'b1;
        repeat (3) step();
        release_dut(d);
        if (d == 0) begin
            repeat (50) step();
        end else begin
            first = -1;
            for (int k = 0; k < 1000 && first < 0; k++) begin
                step();
                if (ft[d]) first = nrel[d];
            end
            chk("ft_after_reset", d, first, FIRST_FT[d]);
        end
    endtask

    initial begin
        // d, n, cntr_h, cntr_v, line_tick, frame_tick, hsync, vsync, blank, rgb_out
        add_vec(0,    0,    0, 0, 0, 0, 0, 0, 1,  0);
        add_vec(0,    1,    1, 0, 0, 0, 0, 0, 1,  0);
        add_vec(0,    2,    2, 0, 0, 0, 0, 0, 0,  0);
        add_vec(0,    5,    5, 0, 0, 0, 0, 0, 0,  3);
        add_vec(0,  801,  801, 0, 0, 0, 0, 0, 0, 31);
        add_vec(0,  802,  802, 0, 0, 0, 0, 0, 1,  0);
        add_vec(0,  857,  857, 0, 0, 0, 0, 0, 1,  0);
        add_vec(0,  858,  858, 0, 0, 0, 1, 0, 1,  0);
        add_vec(0,  977,  977, 0, 0, 0, 1, 0, 1,  0);
        add_vec(0,  978,  978, 0, 0, 0, 0, 0, 1,  0);
        add_vec(0, 1039, 1039, 0, 1, 0, 0, 0, 1,  0);
        add_vec(0, 1040,    0, 1, 0, 0, 0, 0, 1,  0);
        add_vec(0, 1042,    2, 1, 0, 0, 0, 0, 0,  0);
        add_vec(0, 6239, 1039, 5, 1, 0, 0, 0, 1,  0);
        add_vec(0, 6240,    0, 6, 0, 0, 0, 0, 1,  0);
        add_vec(0, 6340,  100, 6, 0, 0, 0, 0, 0, 34);
        add_vec(1,    0,    0, 0, 0, 0, 1, 0, 1,  0);
        add_vec(1,    1,    1, 0, 0, 0, 1, 0, 0,  0);
        add_vec(1,   17,   17, 0, 0, 0, 1, 0, 1,  0);
        add_vec(1,   19,   19, 0, 0, 0, 0, 0, 1,  0);
        add_vec(1,   21,   21, 0, 0, 0, 0, 0, 1,  0);
        add_vec(1,   22,   22, 0, 1, 0, 1, 0, 1,  0);
        add_vec(1,   23,    0, 1, 0, 0, 1, 0, 1,  0);
        add_vec(1,   26,    3, 1, 0, 0, 1, 0, 0,  9);
        add_vec(1,  154,   16, 6, 0, 1, 1, 0, 1,  0);
        add_vec(1,  161,    0, 7, 0, 0, 1, 0, 1,  0);
        add_vec(1,  162,    1, 7, 0, 0, 1, 1, 1,  0);
        add_vec(1,  207,    0, 9, 0, 0, 1, 1, 1,  0);
        add_vec(1,  208,    1, 9, 0, 0, 1, 0, 1,  0);
        add_vec(1,  229,   22, 9, 1, 0, 1, 0, 1,  0);
        add_vec(1,  230,    0, 0, 0, 0, 1, 0, 1,  0);
        add_vec(1,  231,    1, 0, 0, 0, 1, 0, 0,  0);
        add_vec(1,  384,   16, 6, 0, 1, 1, 0, 1,  0);
        add_vec(2,    0,    0, 0, 0, 0, 0, 1, 1,  0);
        add_vec(2,    3,    3, 0, 0, 0, 0, 1, 1,  0);
        add_vec(2,    4,    4, 0, 0, 0, 0, 1, 0,  0);
        add_vec(2,   10,   10, 0, 0, 0, 0, 1, 0,  6);
        add_vec(2,   24,   24, 0, 0, 0, 0, 1, 1,  0);
        add_vec(2,   26,   26, 0, 0, 0, 0, 1, 1,  0);
        add_vec(2,   27,   27, 0, 0, 0, 1, 1, 1,  0);
        add_vec(2,   30,    0, 1, 0, 0, 1, 1, 1,  0);
        add_vec(2,   31,    1, 1, 0, 0, 0, 1, 1,  0);
        add_vec(2,   40,   10, 1, 0, 0, 0, 1, 0, 13);
        add_vec(2,  140,   20, 4, 0, 1, 0, 1, 1,  0);
        add_vec(2,  183,    3, 6, 0, 0, 0, 1, 1,  0);
        add_vec(2,  184,    4, 6, 0, 0, 0, 0, 1,  0);
        add_vec(2,  273,    3, 9, 0, 0, 0, 0, 1,  0);
        add_vec(2,  274,    4, 9, 0, 0, 0, 1, 1,  0);
        add_vec(2,  329,   29, 10, 1, 0, 1, 1, 1, 0);
        add_vec(2,  330,    0, 0, 0, 0, 1, 1, 1,  0);

        rstn = 3'b000;
        pix  = '0;
        tbl_en = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_rst[d]  = 1'b1;
            nrel[d]    = 0;
            last_ft[d] = -1;
        end

        repeat (5) step();
        for (int d = 0; d < 3; d++) release_dut(d);

        repeat (6400) step();
        tbl_en = 1'b0;
        chk("vec_coverage", 0, vec_hits, vec_q.size());

        mid_reset(0, 400, -1);
        mid_reset(1, 8, 3);
        mid_reset(2, 10, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
